// File: rtl/cam_match_iter.sv
// cam_match_iter
//   Walks a 32-bit CAM match vector and emits the index of every set bit,
//   lowest index first, one index per valid/ready beat. An all-zero vector
//   produces a single "no match" beat. The popcount of each accepted vector
//   is latched for status.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     match vector offered
//   in_ready     block can accept a vector (IDLE and no abort)
//   in_match     match vector, bit i = CAM entry i hit
//   abort        synchronous flush of the lookup in progress
//   out_valid    result beat present
//   out_ready    consumer accepts the beat
//   out_idx      matching entry index
//   out_last     final beat of this lookup
//   out_none     lookup had no matches (out_idx = 0)
//   busy         FSM not in IDLE
//   match_count  popcount of the last accepted vector

// prienc_32_5
//   Combinational priority encoder: index of the lowest set bit of req.
//   Returns 0 when req is all zero.
// Ports
//   req  request vector
//   idx  index of the lowest set bit
module prienc_32_5 (
  input  logic [31:0] req,
  output logic [4:0]  idx
);

  // Scan from the top down so that the lowest set bit is written last.
  always_comb begin
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
  end

endmodule

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a match vector; in_ready high unless abort
// ITER  | emitting indices of the remaining set bits in pend
// NONE  | emitting the single "no match" beat for an all-zero vector
module cam_match_iter #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRIES-1:0] in_match,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               out_none,
  output logic               busy,
  output logic [IDX_W:0]     match_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    NONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ENTRIES-1:0] pend, pend_nxt;
  logic [ENTRIES-1:0] pend_clr;
  logic [IDX_W-1:0]   enc_idx;
  logic [IDX_W:0]     pop;
  logic               accept;

  prienc_32_5 u_prienc (
    .req (pend),
    .idx (enc_idx)
  );

  // Clearing the lowest set bit; only consumed in ITER where pend != 0,
  // so the subtraction never wraps in a way that matters.
  assign pend_clr = pend & (pend - 1'b1);

  always_comb begin
    pop = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      pop = pop + (IDX_W+1)'(in_match[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    in_ready  = 1'b0;
    accept    = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready = !abort;
        if (in_valid && !abort) begin
          accept    = 1'b1;
          pend_nxt  = in_match;
          state_nxt = (in_match != '0) ? ITER : NONE;
        end
      end
      ITER: begin
        out_valid = 1'b1;
        out_idx   = enc_idx;
        out_last  = (pend_clr == '0);
        if (abort) begin
          // A coincident handshake is discarded along with the lookup.
          state_nxt = IDLE;
          pend_nxt  = '0;
        end else if (out_ready) begin
          pend_nxt = pend_clr;
          if (pend_clr == '0) state_nxt = IDLE;
        end
      end
      NONE: begin
        out_valid = 1'b1;
        out_none  = 1'b1;
        out_last  = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          pend_nxt  = '0;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      match_count <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (accept) match_count <= pop;
    end
  end

  assign busy = (state != IDLE);

endmodule
